// File: rtl/pattern_detector.sv
// -----------------------------------------------------------------------------
// pattern_detector
//
// Detects a runtime-programmable pattern of 1..MAX_LEN bits on a 1-bit serial
// stream. It supports overlapping or non-overlapping detection, a qualifying
// enable, a saturating match counter and a configuration-error flag.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   en           `in` carries a valid stream bit this cycle
//   in           serial data bit
//   cfg_load     latch cfg_* into the active config and clear the history
//   cfg_pattern  pattern, LSB-aligned; bit [cfg_len-1] is received first
//   cfg_len      pattern length (1..MAX_LEN is valid)
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   cnt_clr      synchronous clear of match_count
//   out          registered one-cycle match strobe
//   match_count  saturating count of matches
//   cfg_err      active length is invalid; detection is disabled
// -----------------------------------------------------------------------------
module pattern_detector #(
    parameter int                   MAX_LEN     = 8,
    parameter int                   LEN_W       = $clog2(MAX_LEN + 1),
    parameter int                   CNT_W       = 16,
    parameter logic [MAX_LEN-1:0]   RST_PATTERN = 8'b0000_0101,
    parameter logic [LEN_W-1:0]     RST_LEN     = LEN_W'(3),
    parameter logic                 RST_OVERLAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 in,
    input  logic                 cfg_load,
    input  logic [MAX_LEN-1:0]   cfg_pattern,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 cfg_overlap,
    input  logic                 cnt_clr,
    output logic                 out,
    output logic [CNT_W-1:0]     match_count,
    output logic                 cfg_err
);

    localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_reg;
    logic [LEN_W-1:0]   fill_reg;
    logic [MAX_LEN-1:0] pattern_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               overlap_reg;
    logic               cfg_err_reg;
    logic               out_reg;
    logic [CNT_W-1:0]   count_reg;

    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               accept;
    logic               match;
    logic               cfg_len_bad;

    // Only the low len bits of history take part in the compare; pattern
    // bits above len are don't-care.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (LEN_W'(gi) < len_reg);
        end
    endgenerate

    // cfg_load wins over en: a bit presented alongside a load is dropped.
    assign accept      = en && !cfg_load;
    assign hist_shift  = {hist_reg[MAX_LEN-2:0], in};
    assign fill_inc    = (fill_reg == FULL) ? FULL : fill_reg + 1'b1;
    assign cfg_len_bad = (cfg_len == '0) || (cfg_len > FULL);

    // Evaluated on the post-shift history so the current bit is included.
    assign match = accept && !cfg_err_reg && (fill_inc >= len_reg) &&
                   (((hist_shift ^ pattern_reg) & len_mask) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_reg    <= '0;
            fill_reg    <= '0;
            pattern_reg <= RST_PATTERN;
            len_reg     <= RST_LEN;
            overlap_reg <= RST_OVERLAP;
            cfg_err_reg <= 1'b0;
            out_reg     <= 1'b0;
        end else if (cfg_load) begin
            hist_reg    <= '0;
            fill_reg    <= '0;
            pattern_reg <= cfg_pattern;
            len_reg     <= cfg_len;
            overlap_reg <= cfg_overlap;
            cfg_err_reg <= cfg_len_bad;
            out_reg     <= 1'b0;
        end else begin
            out_reg <= match;
            if (en) begin
                hist_reg <= hist_shift;
                // Non-overlapping mode demands len fresh bits after a match,
                // so restart the fill count; the history keeps shifting.
                fill_reg <= (match && !overlap_reg) ? '0 : fill_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (cnt_clr) begin
            // A match coinciding with the clear is counted, not lost.
            count_reg <= match ? CNT_W'(1) : '0;
        end else if (match && !(&count_reg)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign out         = out_reg;
    assign match_count = count_reg;
    assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_pattern_detector.sv
module tb_pattern_detector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        in_s = 1'b0;
    logic        cfg_load = 1'b0;
    logic [7:0]  cfg_pattern = '0;
    logic [3:0]  cfg_len = '0;
    logic        cfg_overlap = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        out;
    logic [15:0] match_count;
    logic        cfg_err;
    logic        out2;
    logic [1:0]  match_count2;
    logic        cfg_err2;

    always #5 clk = ~clk;

    pattern_detector #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .in(in_s), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .out(out), .match_count(match_count), .cfg_err(cfg_err)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    pattern_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .in(in_s), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .out(out2), .match_count(match_count2), .cfg_err(cfg_err2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the detector's observable behaviour.
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_err;
    logic [7:0] m_hist;
    int         m_fill;
    int         m_cnt16;
    int         m_cnt2;

    bit          exp_q[$];
    int          pulses;
    logic [31:0] pmask;
    int          idx;

    function automatic bit m_match();
        if (m_err || m_fill < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++)
            if (m_hist[i] !== m_pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic begin_rec();
        pulses = 0;
        pmask  = '0;
        idx    = 0;
    endtask

    task automatic model_reset();
        m_pat = 8'b0000_0101; m_len = 3; m_ovl = 1'b1; m_err = 1'b0;
        m_hist = '0; m_fill = 0; m_cnt16 = 0; m_cnt2 = 0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (out !== 1'b0 || cfg_err !== 1'b0 || match_count !== 16'd0 || match_count2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: out=%b cfg_err=%b count=%0d count2=%0d, required 0/0/0/0",
                     out, cfg_err, match_count, match_count2);
        end
        #1 reset = 1'b0;
        $display("reset applied");
    endtask

    task automatic step(input bit e, input bit b, input bit clr);
        bit exp;
        bit want;
        exp = 1'b0;
        if (e) begin
            m_hist = {m_hist[6:0], b};
            m_fill = (m_fill + 1 > 8) ? 8 : m_fill + 1;
            exp = m_match();
            if (exp && !m_ovl) m_fill = 0;
        end
        if (clr) begin
            m_cnt16 = exp ? 1 : 0;
            m_cnt2  = exp ? 1 : 0;
        end else if (exp) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        exp_q.push_back(exp);
        en = e; in_s = b; cnt_clr = clr; cfg_load = 1'b0;
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (out !== want) begin
            errors++;
            $display("FAIL out_strobe idx=%0d: got %b, required %b", idx, out, want);
        end
        $display("step idx=%0d en=%b in=%b clr=%b out=%b count=%0d", idx, e, b, clr, out, match_count);
        if (out === 1'b1) begin
            pulses++;
            pmask[idx] = 1'b1;
        end
        idx++;
        en = 1'b0; cnt_clr = 1'b0;
    endtask

    // Load with en=1 as well, so the discarded bit is exercised.
    task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
        m_pat = pat; m_len = len; m_ovl = ovl;
        m_err = (len == 0) || (len > 8);
        m_hist = '0; m_fill = 0;
        exp_q.push_back(1'b0);
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        cfg_load = 1'b1; en = 1'b1; in_s = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0; en = 1'b0;
        checks++;
        if (out !== exp_q.pop_front() || cfg_err !== m_err) begin
            errors++;
            $display("FAIL load: out=%b cfg_err=%b, required out=0 cfg_err=%b", out, cfg_err, m_err);
        end
        $display("load pat=%h len=%0d ovl=%b cfg_err=%b", pat, len, ovl, cfg_err);
    endtask

    task automatic stream(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0);
    endtask

    task automatic check_run(input string name, input int want_pulses,
                             input logic [31:0] want_mask, input int want_cnt);
        checks++;
        if (pulses !== want_pulses || pmask !== want_mask) begin
            errors++;
            $display("FAIL %s_pulses: got %0d mask %h, required %0d mask %h",
                     name, pulses, pmask, want_pulses, want_mask);
        end
        checks++;
        if (match_count !== 16'(want_cnt) || match_count !== 16'(m_cnt16)) begin
            errors++;
            $display("FAIL %s_count: got %0d, required %0d", name, match_count, want_cnt);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_default_overlap();
        begin_rec();
        stream(32'b10101, 5);
        check_run("default_overlap", 2, 32'h14, 2);
    endtask

    task automatic test_nonoverlap();
        step(1'b0, 1'b0, 1'b1);
        load(8'b0000_1101, 4'd4, 1'b0);
        begin_rec();
        stream(32'b1101101101, 10);
        check_run("nonoverlap", 2, 32'h208, 2);
    endtask

    task automatic test_overlap();
        step(1'b0, 1'b0, 1'b1);
        load(8'b0000_1101, 4'd4, 1'b1);
        begin_rec();
        stream(32'b1101101101, 10);
        check_run("overlap", 3, 32'h248, 3);
    endtask

    task automatic test_gap();
        do_reset();
        begin_rec();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_run("gap", 1, 32'h80, 1);
    endtask

    task automatic test_cfg_err();
        step(1'b0, 1'b0, 1'b1);
        load(8'h05, 4'd0, 1'b1);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_len0: got %b, required 1", cfg_err);
        end
        begin_rec();
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        load(8'hFF, 4'd9, 1'b1);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_len9: got %b, required 1", cfg_err);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        check_run("cfg_err_quiet", 0, 32'h0, 0);
        load(8'hA5, 4'd8, 1'b1);
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_clear: got %b, required 0", cfg_err);
        end
        begin_rec();
        stream(32'hA5, 8);
        check_run("full_len", 1, 32'h80, 1);
    endtask

    task automatic test_saturate();
        do_reset();
        load(8'h01, 4'd1, 1'b1);
        begin_rec();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        check_run("len1", 5, 32'h1F, 5);
        checks++;
        if (match_count2 !== 2'd3 || match_count2 !== 2'(m_cnt2)) begin
            errors++;
            $display("FAIL saturate: got %0d, required 3", match_count2);
        end
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (match_count !== 16'd1 || match_count2 !== 2'd1) begin
            errors++;
            $display("FAIL clr_with_match: got %0d/%0d, required 1/1", match_count, match_count2);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        do_reset();
        begin_rec();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_run("reset_mid", 1, 32'h4, 1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_overlap();
        test_nonoverlap();
        test_overlap();
        test_gap();
        test_cfg_err();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
